collision_detect: RTL

COLLISION_DETECT -- requirements
Module: collision_detect

---
 rtl/collision_detect.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/collision_detect.sv
// Collision detector for a snake game.
// It watches the scan position for head/prey/body/wall overlaps over one frame.
// At each frame end it decides between eating, game over or nothing.
// It keeps a saturating two-digit BCD score.
module collision_detect #(
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned BORDER   = 10
) (
    input  logic       clk_d,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] xCount,
    input  logic [9:0] yCount,
    input  logic       prey,
    input  logic       head,
    input  logic       body,
    input  logic       updateclock,
    output logic       good_collision,
    output logic       game_over,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones
);

    localparam logic [9:0] XLast   = 10'(H_TOTAL - 1);
    localparam logic [9:0] YLast   = 10'(V_TOTAL - 1);
    localparam logic [9:0] XActive = 10'(H_ACTIVE);
    localparam logic [9:0] YActive = 10'(V_ACTIVE);
    localparam logic [9:0] XLo     = 10'(BORDER);
    localparam logic [9:0] YLo     = 10'(BORDER);
    localparam logic [9:0] XHi     = 10'(H_ACTIVE - BORDER);
    localparam logic [9:0] YHi     = 10'(V_ACTIVE - BORDER);

    typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

    state_e     state_q, state_d;
    logic       upd_meta_q, upd_sync_q, upd_prev_q;
    logic       armed_q;
    logic       hit_prey_q, hit_self_q, hit_wall_q;
    logic       good_q, over_q;
    logic [3:0] tens_q, ones_q;

    logic       frame_end, active, at_wall, tick_rise;
    logic       eat, over_d;

    // Positions past the totals never match the last pixel and never fall inside the active area.
    assign frame_end = (xCount == XLast) && (yCount == YLast);
    assign active    = (xCount < XActive) && (yCount < YActive);
    assign at_wall   = (xCount < XLo) || (xCount >= XHi) || (yCount < YLo) || (yCount >= YHi);
    assign tick_rise = upd_sync_q && !upd_prev_q;

    // Synchronize the slow game tick and remember the previous level for edge detection.
    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            upd_meta_q <= 1'b0;
            upd_sync_q <= 1'b0;
            upd_prev_q <= 1'b0;
        end else begin
            upd_meta_q <= updateclock;
            upd_sync_q <= upd_meta_q;
            upd_prev_q <= upd_sync_q;
        end
    end

    // Armed by each tick and consumed by an eat; a tick arriving on the eat edge re-arms.
    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            armed_q <= 1'b0;
        end else if (tick_rise) begin
            armed_q <= 1'b1;
        end else if (eat) begin
            armed_q <= 1'b0;
        end
    end

    // Sticky per-frame hit flags; clearing at frame end wins over any set.
    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            hit_prey_q <= 1'b0;
            hit_self_q <= 1'b0;
            hit_wall_q <= 1'b0;
        end else if (frame_end) begin
            hit_prey_q <= 1'b0;
            hit_self_q <= 1'b0;
            hit_wall_q <= 1'b0;
        end else if (active) begin
            if (head && prey)    hit_prey_q <= 1'b1;
            if (head && body)    hit_self_q <= 1'b1;
            if (head && at_wall) hit_wall_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (frame_end && start) state_d = StPlay;
            StPlay: begin
                if (!start) begin
                    state_d = StIdle;
                end else if (frame_end && (hit_wall_q || hit_self_q)) begin
                    state_d = StOver;
                end
            end
            StOver: if (!start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM output decode; a bad hit in the same frame suppresses the eat.
    always_comb begin
        eat    = (state_q == StPlay) && start && frame_end && hit_prey_q && armed_q &&
                 !hit_wall_q && !hit_self_q;
        over_d = (state_d == StOver);
    end

    // Registered outputs: one-cycle eat pulse and game-over level.
    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            good_q <= 1'b0;
            over_q <= 1'b0;
        end else begin
            good_q <= eat;
            over_q <= over_d;
        end
    end

    // BCD score, cleared while heading to or sitting in idle, saturating at 99.
    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else if (state_d == StIdle) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else if (eat) begin
            if (ones_q != 4'd9) begin
                ones_q <= ones_q + 4'd1;
            end else if (tens_q != 4'd9) begin
                ones_q <= 4'd0;
                tens_q <= tens_q + 4'd1;
            end
        end
    end

    assign good_collision = good_q;
    assign game_over      = over_q;
    assign score_tens     = tens_q;
    assign score_ones     = ones_q;

endmodule
